// File: rtl/bram_window_reader_pkg.sv
// Shared types and constants for the 3x3 frame-buffer window reader.
package bram_window_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam int WIN_SZ  = 3;
  localparam int N_SLOTS = 9;
  localparam int SLOT_W  = 4;

  // Slot k maps to window offset (k/3, k%3).
  function automatic logic [1:0] slot_row(input logic [SLOT_W-1:0] s);
    return 2'(s / SLOT_W'(WIN_SZ));
  endfunction

  function automatic logic [1:0] slot_col(input logic [SLOT_W-1:0] s);
    return 2'(s % SLOT_W'(WIN_SZ));
  endfunction

endpackage

// File: rtl/bram_window_reader_rd_lat_tracker.sv
// RD_LAT-deep valid/slot pipe that pairs returning read data with its window slot.
module rd_lat_tracker
  import bram_window_reader_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic [SLOT_W-1:0] i_slot,
  output logic              o_vld,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_empty
);

  logic [RD_LAT-1:0] r_vld;
  logic [SLOT_W-1:0] r_slot [RD_LAT];
  logic              w_pending;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_slot[0] <= i_slot;
    for (int i = 1; i < RD_LAT; i++) r_slot[i] <= r_slot[i-1];
  end

  // Empty means nothing is outstanding once the entry at the tail retires.
  always_comb begin
    w_pending = i_vld;
    for (int i = 0; i < RD_LAT - 1; i++) w_pending = w_pending | r_vld[i];
  end

  assign o_vld   = r_vld[RD_LAT-1];
  assign o_slot  = r_slot[RD_LAT-1];
  assign o_empty = !w_pending;

endmodule

// File: rtl/bram_window_reader.sv
// Raster-scans a loaded HxW frame and streams every 3x3 window on valid/ready.
// Optional macro WIN_COLUMN_REUSE_EN: same-row advances refetch only the new column.
module bram_window_reader
  import bram_window_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 16,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  all_loaded,
  input  logic [DIM_W-1:0]      H,
  input  logic [DIM_W-1:0]      W,
  output logic [DIM_W-1:0]      read_H,
  output logic [DIM_W-1:0]      read_W,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic [DIM_W-1:0]      win_row,
  output logic [DIM_W-1:0]      win_col,
  output logic                  busy,
  output logic                  frame_done
);

`ifdef WIN_COLUMN_REUSE_EN
  localparam bit REUSE = 1'b1;
  localparam logic [SLOT_W-1:0] SAME_ROW_FIRST = SLOT_W'(2);
`else
  localparam bit REUSE = 1'b0;
  localparam logic [SLOT_W-1:0] SAME_ROW_FIRST = SLOT_W'(0);
`endif
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
  localparam logic [DIM_W-1:0]  ONE       = DIM_W'(1);
  localparam logic [DIM_W-1:0]  WSZ       = DIM_W'(WIN_SZ);

  state_t              r_state;
  logic [DIM_W-1:0]    r_h, r_w, r_row, r_col, r_read_h, r_read_w;
  logic                r_partial, r_rd_vld, r_win_valid, r_busy, r_frame_done;
  logic [SLOT_W-1:0]   r_rd_slot;
  logic [DATA_W-1:0]   r_win [N_SLOTS];
  logic                w_abort, w_tail_vld, w_empty, w_same_row, w_next_row;
  logic [SLOT_W-1:0]   w_tail_slot, w_next_slot;

  function automatic logic [DIM_W-1:0] coord(input logic [DIM_W-1:0] org, input logic [1:0] off);
    return org + DIM_W'(off);
  endfunction

  assign w_abort     = (r_state != S_IDLE) && !all_loaded;
  assign w_same_row  = r_col < (r_w - WSZ);
  assign w_next_row  = r_row < (r_h - WSZ);
  assign w_next_slot = r_partial ? (r_rd_slot + SLOT_W'(3)) : (r_rd_slot + SLOT_W'(1));

  rd_lat_tracker #(.RD_LAT(RD_LAT)) u_trk (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_abort),
    .i_vld   (r_rd_vld),
    .i_slot  (r_rd_slot),
    .o_vld   (w_tail_vld),
    .o_slot  (w_tail_slot),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_h          <= '0;
      r_w          <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_read_h     <= '0;
      r_read_w     <= '0;
      r_partial    <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_slot    <= '0;
      r_win_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_win_valid <= 1'b0;
        r_rd_vld    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (start && all_loaded) begin
            r_h    <= H;
            r_w    <= W;
            r_row  <= '0;
            r_col  <= '0;
            r_busy <= 1'b1;
            if (H < WSZ || W < WSZ) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state   <= S_ISSUE;
              r_partial <= 1'b0;
              r_rd_vld  <= 1'b1;
              r_rd_slot <= '0;
              r_read_h  <= '0;
              r_read_w  <= '0;
            end
          end
          S_ISSUE: begin
            if (r_rd_slot == LAST_SLOT) begin
              r_rd_vld <= 1'b0;
              r_state  <= S_DRAIN;
            end else begin
              r_rd_slot <= w_next_slot;
              r_read_h  <= coord(r_row, slot_row(w_next_slot));
              r_read_w  <= coord(r_col, slot_col(w_next_slot));
            end
          end
          S_DRAIN: if (w_empty) begin
            r_state     <= S_PRESENT;
            r_win_valid <= 1'b1;
          end
          S_PRESENT: if (win_ready) begin
            r_win_valid <= 1'b0;
            if (w_same_row) begin
              r_col     <= r_col + ONE;
              r_state   <= S_ISSUE;
              r_partial <= REUSE;
              r_rd_vld  <= 1'b1;
              r_rd_slot <= SAME_ROW_FIRST;
              r_read_h  <= coord(r_row, slot_row(SAME_ROW_FIRST));
              r_read_w  <= coord(r_col + ONE, slot_col(SAME_ROW_FIRST));
            end else if (w_next_row) begin
              r_row     <= r_row + ONE;
              r_col     <= '0;
              r_state   <= S_ISSUE;
              r_partial <= 1'b0;
              r_rd_vld  <= 1'b1;
              r_rd_slot <= '0;
              r_read_h  <= r_row + ONE;
              r_read_w  <= '0;
            end else begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Window slot storage: filled from the tracker tail, shifted on reuse advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < N_SLOTS; s++) r_win[s] <= '0;
    end else begin
      if (w_tail_vld && !w_abort) r_win[w_tail_slot] <= rd_data;
`ifdef WIN_COLUMN_REUSE_EN
      if (r_state == S_PRESENT && win_ready && !w_abort && w_same_row) begin
        for (int r = 0; r < WIN_SZ; r++) begin
          r_win[r*WIN_SZ]     <= r_win[r*WIN_SZ + 1];
          r_win[r*WIN_SZ + 1] <= r_win[r*WIN_SZ + 2];
        end
      end
`endif
    end
  end

  always_comb begin
    win_data = '0;
    for (int s = 0; s < N_SLOTS; s++) win_data[s*DATA_W +: DATA_W] = r_win[s];
  end

  assign read_H     = r_read_h;
  assign read_W     = r_read_w;
  assign win_valid  = r_win_valid;
  assign win_row    = r_row;
  assign win_col    = r_col;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bram_window_reader.sv
// Randomized scoreboard bench for bram_window_reader against a frame-level window model.
module tb_bram_window_reader;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 16;
  localparam int RD_LAT = 2;
`ifdef WIN_COLUMN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start, all_loaded, win_ready;
  logic [DIM_W-1:0]    H, W, read_H, read_W, win_row, win_col;
  logic [DATA_W-1:0]   rd_data;
  logic                win_valid, busy, frame_done;
  logic [9*DATA_W-1:0] win_data;

  bram_window_reader #(.DATA_W(DATA_W), .DIM_W(DIM_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .all_loaded(all_loaded),
    .H(H), .W(W), .read_H(read_H), .read_W(read_W), .rd_data(rd_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [DATA_W-1:0] pix(int h, int w);
    return DATA_W'(h * 16 + w);
  endfunction

  // Frame buffer model: returns the pixel addressed RD_LAT cycles earlier.
  logic [DATA_W-1:0] lat_pipe [RD_LAT];
  always @(posedge clk) begin
    lat_pipe[0] <= pix(int'(read_H), int'(read_W));
    for (int i = 1; i < RD_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
  end
  assign rd_data = lat_pipe[RD_LAT-1];

  typedef struct {
    logic [9*DATA_W-1:0] data;
    int row;
    int col;
    int lat;
  } win_t;
  win_t exp_q[$];

  int n_checks = 0, n_errs = 0;
  int cyc = 0, t0_cyc = 0, last_evt = 0, fd_seen = 0;
  bit prev_valid = 1'b0, busy_chk = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic build(input int h, input int w);
    exp_q.delete();
    if (h < 3 || w < 3) return;
    for (int r = 0; r <= h - 3; r++)
      for (int c = 0; c <= w - 3; c++) begin
        win_t e;
        e.data = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            e.data[(rr*3+cc)*DATA_W +: DATA_W] = pix(r + rr, c + cc);
        e.row = r;
        e.col = c;
        e.lat = (REUSE && c != 0) ? 3 + RD_LAT : 9 + RD_LAT;
        exp_q.push_back(e);
      end
  endtask

  // One clock: scoreboard at negedge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (busy_chk) begin
      check_eq("busy_after_done", busy, 1'b0);
      check_eq("done_one_cycle", frame_done, 1'b0);
      busy_chk = 1'b0;
    end
    if (!reset) begin
      if (start && all_loaded && !busy) begin
        t0_cyc   = cyc + 1;
        last_evt = cyc;
      end
      if (win_valid) begin
        if (exp_q.size() == 0) check_eq("unexpected_valid", win_valid, 1'b0);
        else begin
          if (!prev_valid) check_eq("valid_latency", cyc - t0_cyc, exp_q[0].lat);
          check_eq("win_row", win_row, exp_q[0].row);
          check_eq("win_col", win_col, exp_q[0].col);
          check_eq("win_data", win_data, exp_q[0].data);
          check_eq("hold_read_H", read_H, exp_q[0].row + 2);
          check_eq("hold_read_W", read_W, exp_q[0].col + 2);
          if (win_ready) begin
            void'(exp_q.pop_front());
            t0_cyc   = cyc + 1;
            last_evt = cyc;
          end
        end
      end
      if (frame_done) begin
        fd_seen++;
        check_eq("frame_done_time", cyc, last_evt + 1);
        check_eq("windows_left", exp_q.size(), 0);
        busy_chk = 1'b1;
      end
    end
    prev_valid = win_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_rst(input string pfx);
    @(negedge clk);
    check_eq({pfx, "_read_H"}, read_H, 0);
    check_eq({pfx, "_read_W"}, read_W, 0);
    check_eq({pfx, "_valid"}, win_valid, 0);
    check_eq({pfx, "_data"}, win_data, 0);
    check_eq({pfx, "_row"}, win_row, 0);
    check_eq({pfx, "_col"}, win_col, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, frame_done, 0);
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: ready always, 1: random ready, 2: stall window (0,1) for 7 cycles
  task automatic run_frame(input int h, input int w, input int mode);
    int fd0, budget, stall;
    H = DIM_W'(h);
    W = DIM_W'(w);
    build(h, w);
    fd0 = fd_seen;
    budget = 0;
    stall = 0;
    start = 1'b1;
    win_ready = 1'b1;
    cycle();
    start = 1'b0;
    while (fd_seen == fd0 && budget < 3000) begin
      case (mode)
        1: win_ready = ($urandom_range(0, 3) != 0);
        2: if (win_valid && win_row == 0 && win_col == 1 && stall < 7) begin
             win_ready = 1'b0;
             stall++;
           end else win_ready = 1'b1;
        default: win_ready = 1'b1;
      endcase
      cycle();
      budget++;
    end
    check_eq("frame_timeout", budget < 3000, 1'b1);
    check_eq("frame_done_count", fd_seen - fd0, 1);
    if (mode == 2) check_eq("stall_cycles", stall, 7);
    win_ready = 1'b1;
    cycle();
  endtask

  initial begin
    int fd0, budget;
    reset = 1'b1; start = 1'b0; all_loaded = 1'b1; win_ready = 1'b0;
    H = '0; W = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_rst("rst");

    run_frame(4, 4, 0);
    run_frame(4, 4, 2);
    run_frame(2, 5, 0);

    // Abort in the middle of the first window's drain
    H = 16'd4; W = 16'd4;
    build(4, 4);
    fd0 = fd_seen;
    start = 1'b1; win_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (9) cycle();
    all_loaded = 1'b0;
    cycle();
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_valid", win_valid, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    repeat (4) cycle();
    check_eq("abort_no_done", fd_seen - fd0, 0);
    all_loaded = 1'b1;
    run_frame(4, 4, 0);

    // Reset while a window is being presented
    H = 16'd4; W = 16'd4;
    build(4, 4);
    start = 1'b1; win_ready = 1'b0;
    cycle();
    start = 1'b0;
    budget = 0;
    while (!win_valid && budget < 60) begin
      cycle();
      budget++;
    end
    check_eq("reach_present", win_valid, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    check_rst("present_rst");

    // Start without a loaded frame is ignored
    all_loaded = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    @(negedge clk);
    check_eq("start_ignored_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    all_loaded = 1'b1;

    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(3, 6), $urandom_range(3, 6), 1);
    run_frame($urandom_range(1, 2), $urandom_range(1, 8), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
